// File: rtl/sa_tile_feeder.sv
// Row-stream skew feeder for the weight-stationary SA: lane k lags k PE steps, advances only on I_PE_SHIFT.
// All outputs registered; one-row hold buffer, O_X_RDY low while the hold is full or the tile's rows are in.
module sa_tile_feeder #(
  parameter int D_W     = 8,
  parameter int S       = 64,
  parameter int W_C     = 64,
  parameter int X_R_MAX = 64,
  parameter int RW      = $clog2(X_R_MAX + 1)
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_START,
  input  logic [RW-1:0]    I_ROWS,
  input  logic             I_X_VLD,
  input  logic [S*D_W-1:0] I_X_ROW,
  output logic             O_X_RDY,
  input  logic             I_PE_SHIFT,
  output logic [S*D_W-1:0] O_SA_X,
  output logic             O_END_FLAG,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_UNDERFLOW
);

  localparam int SW   = $clog2(X_R_MAX + S + W_C);
  localparam int TAIL = S - 1 + W_C;
  localparam int AW   = RW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_END} state_t;

  state_t           state_r, state_nxt;
  logic [RW-1:0]    rows_r;
  logic [SW-1:0]    step_r, step_inc, total;
  logic [AW-1:0]    acc_r, acc_nxt;
  logic [S*D_W-1:0] hold_r, inj_row;
  logic             hold_vld_r, hold_vld_nxt;
  logic             x_rdy_r, end_r, busy_r, uflow_r;
  logic             rows_legal, start_ok, active, shift_en, hs, feed_slot, slot_empty;

  always_comb begin
    rows_legal   = (I_ROWS != '0) && (I_ROWS <= RW'(X_R_MAX));
    start_ok     = I_START && rows_legal;
    active       = (state_r == ST_FEED) || (state_r == ST_DRAIN);
    // a legal start wins over any coincident shift or handshake
    shift_en     = I_PE_SHIFT && active && !start_ok;
    hs           = I_X_VLD && x_rdy_r && !start_ok;
    feed_slot    = shift_en && (state_r == ST_FEED);
    slot_empty   = feed_slot && !hold_vld_r;
    step_inc     = step_r + 1'b1;
    total        = SW'(rows_r) + SW'(TAIL);
    inj_row      = ((state_r == ST_FEED) && hold_vld_r) ? hold_r : '0;
    hold_vld_nxt = hold_vld_r;
    if (feed_slot) hold_vld_nxt = 1'b0;
    if (hs)        hold_vld_nxt = 1'b1;
    acc_nxt      = acc_r + AW'(hs) + AW'(slot_empty);
  end

  always_comb begin
    state_nxt = state_r;
    if (start_ok) begin
      state_nxt = ST_FEED;
    end else begin
      case (state_r)
        ST_FEED: begin
          if (shift_en) begin
            if (step_inc == total)              state_nxt = ST_END;
            else if (step_inc == SW'(rows_r))   state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (shift_en && (step_inc == total))  state_nxt = ST_END;
        end
        ST_END:  state_nxt = ST_IDLE;
        default: state_nxt = state_r;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state_r <= ST_IDLE;
    else          state_r <= state_nxt;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      rows_r     <= '0;
      step_r     <= '0;
      acc_r      <= '0;
      hold_r     <= '0;
      hold_vld_r <= 1'b0;
      uflow_r    <= 1'b0;
    end else if (start_ok) begin
      rows_r     <= I_ROWS;
      step_r     <= '0;
      acc_r      <= '0;
      hold_vld_r <= 1'b0;
      uflow_r    <= 1'b0;
    end else begin
      if (shift_en)   step_r  <= step_inc;
      if (slot_empty) uflow_r <= 1'b1;
      if (hs)         hold_r  <= I_X_ROW;
      hold_vld_r <= hold_vld_nxt;
      acc_r      <= acc_nxt;
    end
  end

  // status outputs are registered from next-state values so they line up with the FSM
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      x_rdy_r <= 1'b0;
      end_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (start_ok) x_rdy_r <= 1'b1;
      else          x_rdy_r <= (state_nxt == ST_FEED) && !hold_vld_nxt && (acc_nxt < {1'b0, rows_r});
      end_r  <= (state_nxt == ST_END);
      busy_r <= (state_nxt != ST_IDLE);
    end
  end

  // lane k: k skew stages plus the output stage, all advancing on the PE step
  for (genvar k = 0; k < S; k++) begin : g_lane
    logic [D_W-1:0] pipe [k+1];

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
        for (int j = 0; j <= k; j++) pipe[j] <= '0;
      end else if (start_ok) begin
        for (int j = 0; j <= k; j++) pipe[j] <= '0;
      end else if (shift_en) begin
        pipe[0] <= inj_row[k*D_W +: D_W];
        for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
      end
    end

    assign O_SA_X[k*D_W +: D_W] = pipe[k];
  end

  assign O_X_RDY     = x_rdy_r;
  assign O_END_FLAG  = end_r;
  assign O_DONE      = end_r;
  assign O_BUSY      = busy_r;
  assign O_UNDERFLOW = uflow_r;

endmodule

// File: tb/tb_sa_tile_feeder.sv
// Bench for sa_tile_feeder: tile table plus random tiles against a row-history model, then abort/reset sequences.
module tb_sa_tile_feeder;

  localparam int D_W     = 8;
  localparam int S       = 4;
  localparam int W_C     = 2;
  localparam int X_R_MAX = 6;
  localparam int RW      = $clog2(X_R_MAX + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [RW-1:0]    rows_in;
  logic             x_vld;
  logic [S*D_W-1:0] x_row;
  logic             x_rdy;
  logic             pe_shift;
  logic [S*D_W-1:0] sa_x;
  logic             end_flag, busy, done, underflow;

  sa_tile_feeder #(.D_W(D_W), .S(S), .W_C(W_C), .X_R_MAX(X_R_MAX), .RW(RW)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_ROWS(rows_in),
    .I_X_VLD(x_vld), .I_X_ROW(x_row), .O_X_RDY(x_rdy), .I_PE_SHIFT(pe_shift),
    .O_SA_X(sa_x), .O_END_FLAG(end_flag), .O_BUSY(busy), .O_DONE(done),
    .O_UNDERFLOW(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rows;
    int wh;
    int gap;
    bit fixed;
    int exp_pulses;
    bit exp_uf;
  } vec_t;

  vec_t             tbl [5];
  int               checks = 0;
  int               errors = 0;
  int               end_cnt = 0;
  logic [S*D_W-1:0] rowdat [1:X_R_MAX];

  always @(negedge clk) if (end_flag === 1'b1) end_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lane k after pulse p carries element k of the row injected at pulse p-k
  function automatic logic [S*D_W-1:0] exp_lanes(input int p, input int rows);
    logic [S*D_W-1:0] v;
    logic [S*D_W-1:0] r;
    v = '0;
    for (int k = 0; k < S; k++) begin
      if (p - k >= 1 && p - k <= rows) begin
        r = rowdat[p-k];
        v[k*D_W +: D_W] = r[k*D_W +: D_W];
      end
    end
    return v;
  endfunction

  task automatic start_tile(input int n);
    start = 1'b1;
    rows_in = RW'(n);
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rdy", x_rdy, 1);
    chk("start_lanes", sa_x, 0);
    chk("start_uflow", underflow, 0);
  endtask

  task automatic present_row(input logic [S*D_W-1:0] r);
    int n;
    x_vld = 1'b1;
    x_row = r;
    n = 0;
    while (x_rdy !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk("rdy_wait", n < 40, 1);
    tick;
    x_vld = 1'b0;
    chk("rdy_drop", x_rdy, 0);
  endtask

  task automatic pulse;
    pe_shift = 1'b1;
    tick;
    pe_shift = 1'b0;
  endtask

  task automatic run_body(input int rows, input int wh, input int gap, input bit fixed,
                          input int exp_pulses, input bit exp_uf);
    int e0;
    e0 = end_cnt;
    for (int p = 1; p <= exp_pulses; p++) begin
      if (p <= rows) begin
        if (p == wh) begin
          rowdat[p] = '0;
        end else begin
          rowdat[p] = fixed ? {8'(4*p), 8'(4*p-1), 8'(4*p-2), 8'(4*p-3)} : $urandom;
          present_row(rowdat[p]);
        end
      end
      repeat (gap) tick;
      pulse;
      chk("lanes", sa_x, exp_lanes(p, rows));
      chk("end_flag", end_flag, p == exp_pulses);
      chk("done", done, p == exp_pulses);
      chk("underflow", underflow, (wh != 0) && (p >= wh));
      if (p >= rows) chk("rdy_drain", x_rdy, 0);
    end
    chk("final_uflow", underflow, exp_uf);
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_end", end_flag, 0);
    chk("end_once", end_cnt - e0, 1);
  endtask

  initial begin
    int r, w, g;
    int e0;
    rst_n = 1'b0; start = 1'b0; rows_in = '0; x_vld = 1'b0; x_row = '0; pe_shift = 1'b0;

    tbl[0] = '{3, 0, 4, 1'b1, 8, 1'b0};
    tbl[1] = '{1, 0, 1, 1'b0, 6, 1'b0};
    tbl[2] = '{6, 0, 0, 1'b0, 11, 1'b0};
    tbl[3] = '{4, 2, 2, 1'b0, 9, 1'b1};
    tbl[4] = '{2, 1, 0, 1'b0, 7, 1'b1};

    #3;
    chk("rst_rdy", x_rdy, 0);
    chk("rst_lanes", sa_x, 0);
    chk("rst_end", end_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_uflow", underflow, 0);
    #10 rst_n = 1'b1;
    tick;

    // illegal row counts are ignored in IDLE
    start = 1'b1; rows_in = RW'(0); tick; start = 1'b0;
    chk("ill0_busy", busy, 0);
    chk("ill0_rdy", x_rdy, 0);
    start = 1'b1; rows_in = RW'(X_R_MAX + 1); tick; start = 1'b0;
    chk("ill7_busy", busy, 0);
    tick;
    chk("ill7_busy2", busy, 0);

    for (int i = 0; i < 5; i++) begin
      start_tile(tbl[i].rows);
      run_body(tbl[i].rows, tbl[i].wh, tbl[i].gap, tbl[i].fixed, tbl[i].exp_pulses, tbl[i].exp_uf);
    end

    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(1, X_R_MAX);
      w = $urandom_range(0, r);
      g = $urandom_range(0, 3);
      start_tile(r);
      run_body(r, w, g, 1'b0, r + S - 1 + W_C, w != 0);
    end

    // abort mid-DRAIN with a coincident shift
    e0 = end_cnt;
    start_tile(2);
    for (int p = 1; p <= 4; p++) begin
      if (p <= 2) begin
        rowdat[p] = $urandom | 32'h01010101;
        present_row(rowdat[p]);
      end
      pulse;
      chk("pre_abort_lanes", sa_x, exp_lanes(p, 2));
    end
    start = 1'b1; rows_in = RW'(3); pe_shift = 1'b1;
    tick;
    start = 1'b0; pe_shift = 1'b0;
    chk("abort_lanes", sa_x, 0);
    chk("abort_busy", busy, 1);
    chk("abort_end", end_flag, 0);
    chk("abort_rdy", x_rdy, 1);
    run_body(3, 0, 1, 1'b0, 8, 1'b0);
    chk("abort_end_total", end_cnt - e0, 1);

    // asynchronous reset in the middle of FEED
    start_tile(3);
    rowdat[1] = 32'h11223344;
    present_row(rowdat[1]);
    pulse;
    chk("pre_rst_lanes", sa_x, 32'h00000044);
    rowdat[2] = 32'h55667788;
    present_row(rowdat[2]);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lanes", sa_x, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", x_rdy, 0);
    chk("arst_end", end_flag, 0);
    chk("arst_done", done, 0);
    chk("arst_uflow", underflow, 0);
    #2;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", busy, 0);
    start_tile(tbl[0].rows);
    run_body(tbl[0].rows, tbl[0].wh, tbl[0].gap, tbl[0].fixed, tbl[0].exp_pulses, tbl[0].exp_uf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
